mem_io_ctrl: RTL and testbench
==============================

// Module: mem_io_ctrl
// PURPOSE
//  Responder end of the cpu external byte bus (mem_a/mem_dout/mem_wr out, mem_din in).
//  Holds 128KB byte RAM, decodes I/O window (addr[17:16]==2'b11), buffers UART tx bytes,
//  supplies UART rx bytes and free-running cycle counter, flags program stop.
//  Sits beside cpu in the top-level harness; cpu's memory unit is its only master.
// PARAMETERS
//  RAM_ADDR_W    17  RAM byte-address bits (2**17 = 128KB)
//  TX_DEPTH_LOG  3   log2 of tx FIFO depth (8 entries)
// PORTS
//  clk_in         in   1   clock; all state updates on rising edge
//  rst_in         in   1   reset, synchronous, active-high
//  in_mem_a       in   32  byte address from cpu (only [17:0] decoded)
//  in_mem_dout    in   8   write data from cpu
//  in_mem_wr      in   1   1 = write this cycle, 0 = read
//  out_mem_din    out  8   read data to cpu, valid cycle after request
//  out_io_full    out  1   tx buffer nearly full (drives cpu io_buffer_full)
//  in_rx_valid    in   1   uart rx byte available
//  in_rx_data     in   8   uart rx byte
//  out_rx_ack     out  1   rx byte consumed this cycle
//  out_tx_valid   out  1   tx FIFO head valid
//  out_tx_data    out  8   tx FIFO head byte
//  in_tx_ready    in   1   uart tx accepts head when valid&ready
//  out_tx_ovf     out  1   sticky: tx byte dropped (FIFO full)
//  out_stop       out  1   sticky: program stop completed
// BEHAVIOUR
//  Reset: out_mem_din=0, out_io_full=0, out_rx_ack=0, out_tx_valid=0, out_tx_data=0,
//   out_tx_ovf=0, out_stop=0; FIFO empty; counter=0; snapshot=0; state RUN.
//  Decode: io = in_mem_a[17:16]==2'b11; else RAM addr = in_mem_a[RAM_ADDR_W-1:0].
//  RAM write: byte stored at edge of cycle with in_mem_wr=1; out_mem_din next cycle = 0x00.
//  RAM read: out_mem_din = RAM[addr] exactly 1 cycle later (registered); read of byte
//   written previous cycle returns new value.
//  Counter: 32-bit, +1 every cycle from reset, wraps 0xFFFFFFFF->0.
//  IO read 0x30000: if in_rx_valid, out_mem_din<=in_rx_data, out_rx_ack=1 (combinational,
//   same cycle as request); else out_mem_din<=0x00, no ack.
//  IO read 0x30004: snapshot<=counter, out_mem_din<=counter[7:0];
//   0x30005/6/7 return snapshot[15:8]/[23:16]/[31:24] (little-endian, coherent word).
//  IO write 0x30000: data 0x00 ignored; else push into FIFO; push when full and no pop
//   same cycle -> byte dropped, out_tx_ovf<=1.
//  IO write 0x30004: RUN->STOP_PEND. STOP_PEND: push 0x00 when FIFO has room (count<depth
//   or pop same cycle) -> DRAIN. DRAIN: when FIFO empty and no push -> STOPPED, out_stop<=1.
//   STOP_PEND/DRAIN/STOPPED: all IO writes ignored; RAM and reads still served.
//  Other IO addresses: read 0x00, write ignored.
//  FIFO: pop when out_tx_valid&in_tx_ready; simultaneous push+pop keeps count; head
//   registered, out_tx_valid = count!=0; pointers wrap modulo depth.
//  out_io_full registered: 1 when count >= depth-1 after this edge (one-slot margin for
//   a write already in flight from cpu).
//  Reset mid-operation (incl. STOP_PEND/DRAIN) clears everything to reset values; RAM
//   contents not cleared.
// TESTING
//  1 Write 0xA5 to 0x00010, read 0x00010 next cycle -> out_mem_din=0xA5 one cycle later.
//  2 Write 'H','i',0x00 to 0x30000, in_tx_ready=1 -> tx sees 0x48,0x69 only, ovf=0.
//  3 in_tx_ready=0, write 9 nonzero bytes -> out_io_full=1 after 7th, 9th dropped, ovf=1.
//  4 Wait 0x123 cycles after reset, read 0x30004..7 -> bytes match snapshot little-endian,
//    byte1..3 unaffected by counter advancing between reads.
//  5 in_rx_valid=1,data=0x3C, read 0x30000 -> out_rx_ack pulse, out_mem_din=0x3C next;
//    rx_valid=0 -> 0x00, no ack.
//  6 FIFO full, in_tx_ready=0, write 0x30004 -> stop waits; release ready -> 0x00 sent
//    last, out_stop=1 after FIFO empties; later write 0x30000 ignored.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// Byte-bus responder for the cpu: 128KB RAM, memory-mapped UART/counter I/O window,
// tx byte FIFO with overflow flag, and a program-stop sequencer that drains the FIFO.
module mem_io_ctrl #(
   parameter int RAM_ADDR_W   = 17,
   parameter int TX_DEPTH_LOG = 3
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] in_mem_a,
   input  logic [7:0]  in_mem_dout,
   input  logic        in_mem_wr,
   output logic [7:0]  out_mem_din,
   output logic        out_io_full,
   input  logic        in_rx_valid,
   input  logic [7:0]  in_rx_data,
   output logic        out_rx_ack,
   output logic        out_tx_valid,
   output logic [7:0]  out_tx_data,
   input  logic        in_tx_ready,
   output logic        out_tx_ovf,
   output logic        out_stop
);

   localparam int DEPTH = 1 << TX_DEPTH_LOG;
   localparam int CNT_W = TX_DEPTH_LOG + 1;

   localparam logic [17:0] A_DATA  = 18'h30000;
   localparam logic [17:0] A_CTRL  = 18'h30004;
   localparam logic [17:0] A_SNAP1 = 18'h30005;
   localparam logic [17:0] A_SNAP2 = 18'h30006;
   localparam logic [17:0] A_SNAP3 = 18'h30007;

   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_HIGH  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      RUN,
      STOP_PEND,
      DRAIN,
      STOPPED
   } state_t;

   state_t state;

   logic [7:0] ram  [0:(1 << RAM_ADDR_W) - 1];
   logic [7:0] fifo [0:DEPTH - 1];

   logic [TX_DEPTH_LOG-1:0] rd_ptr;
   logic [TX_DEPTH_LOG-1:0] wr_ptr;
   logic [TX_DEPTH_LOG-1:0] rd_ptr_next;
   logic [CNT_W-1:0]        count;
   logic [CNT_W-1:0]        count_next;
   logic [31:0]             counter;
   logic [31:0]             snapshot;

   logic [17:0]           io_addr;
   logic [RAM_ADDR_W-1:0] ram_addr;
   logic                  io_sel;
   logic                  io_wr;
   logic                  rx_read;
   logic                  pop;
   logic                  room;
   logic                  user_push;
   logic                  stop_push;
   logic                  push;
   logic                  drop;
   logic                  empty_after_pop;
   logic [7:0]            push_data;
   logic [7:0]            head_next;
   logic                  unused_addr;

   assign io_addr     = in_mem_a[17:0];
   assign ram_addr    = in_mem_a[RAM_ADDR_W-1:0];
   assign io_sel      = (in_mem_a[17:16] == 2'b11);
   assign unused_addr = ^in_mem_a[31:18];

   // I/O writes only take effect while the program is running
   assign io_wr      = io_sel && in_mem_wr && (state == RUN);
   assign rx_read    = io_sel && !in_mem_wr && (io_addr == A_DATA);
   assign out_rx_ack = !rst_in && rx_read && in_rx_valid;

   assign pop       = out_tx_valid && in_tx_ready;
   assign room      = (count != CNT_DEPTH) || pop;
   assign user_push = io_wr && (io_addr == A_DATA) && (in_mem_dout != 8'h00);
   assign stop_push = (state == STOP_PEND) && room;
   assign push      = (user_push || stop_push) && room;
   assign drop      = user_push && !room;
   assign push_data = stop_push ? 8'h00 : in_mem_dout;

   assign rd_ptr_next     = pop ? rd_ptr + 1'b1 : rd_ptr;
   assign empty_after_pop = pop ? (count == CNT_ONE) : (count == '0);

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + CNT_ONE;
      end else if (pop && !push) begin
         count_next = count - CNT_ONE;
      end
   end

   // head register: next entry in storage, or the byte being pushed into an emptying FIFO
   always_comb begin
      head_next = out_tx_data;
      if (!empty_after_pop) begin
         head_next = fifo[rd_ptr_next];
      end else if (push) begin
         head_next = push_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (in_mem_wr && !io_sel) begin
         ram[ram_addr] <= in_mem_dout;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         out_tx_valid <= 1'b0;
         out_tx_data  <= 8'h00;
         out_io_full  <= 1'b0;
         out_tx_ovf   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr       <= rd_ptr_next;
         count        <= count_next;
         out_tx_valid <= (count_next != '0);
         out_tx_data  <= head_next;
         out_io_full  <= (count_next >= CNT_HIGH);
         if (drop) begin
            out_tx_ovf <= 1'b1;
         end
      end
   end

   // read path: one registered cycle for RAM and I/O alike; writes return zero
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         counter     <= 32'd0;
         snapshot    <= 32'd0;
         out_mem_din <= 8'h00;
      end else begin
         counter <= counter + 32'd1;
         if (in_mem_wr) begin
            out_mem_din <= 8'h00;
         end else if (!io_sel) begin
            out_mem_din <= ram[ram_addr];
         end else begin
            case (io_addr)
               A_DATA:  out_mem_din <= in_rx_valid ? in_rx_data : 8'h00;
               A_CTRL: begin
                  snapshot    <= counter;
                  out_mem_din <= counter[7:0];
               end
               A_SNAP1: out_mem_din <= snapshot[15:8];
               A_SNAP2: out_mem_din <= snapshot[23:16];
               A_SNAP3: out_mem_din <= snapshot[31:24];
               default: out_mem_din <= 8'h00;
            endcase
         end
      end
   end

   // stop sequence: queue a 0x00 terminator, wait for it to leave, then flag stop
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= RUN;
         out_stop <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (io_wr && (io_addr == A_CTRL)) begin
                  state <= STOP_PEND;
               end
            end
            STOP_PEND: begin
               if (room) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((count == '0) && !push) begin
                  state    <= STOPPED;
                  out_stop <= 1'b1;
               end
            end
            default: begin
               state <= STOPPED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: a transaction-level model predicts read data, rx acks,
// status flags and the tx byte stream; a negedge monitor compares them as they fall due.
module tb_mem_io_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [31:0] in_mem_a = 32'h0003000C;
   logic [7:0]  in_mem_dout = 8'h00;
   logic        in_mem_wr = 1'b0;
   logic [7:0]  out_mem_din;
   logic        out_io_full;
   logic        in_rx_valid = 1'b0;
   logic [7:0]  in_rx_data = 8'h00;
   logic        out_rx_ack;
   logic        out_tx_valid;
   logic [7:0]  out_tx_data;
   logic        in_tx_ready = 1'b0;
   logic        out_tx_ovf;
   logic        out_stop;

   always #5 clk_in = ~clk_in;

   mem_io_ctrl dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .in_mem_a    (in_mem_a),
      .in_mem_dout (in_mem_dout),
      .in_mem_wr   (in_mem_wr),
      .out_mem_din (out_mem_din),
      .out_io_full (out_io_full),
      .in_rx_valid (in_rx_valid),
      .in_rx_data  (in_rx_data),
      .out_rx_ack  (out_rx_ack),
      .out_tx_valid(out_tx_valid),
      .out_tx_data (out_tx_data),
      .in_tx_ready (in_tx_ready),
      .out_tx_ovf  (out_tx_ovf),
      .out_stop    (out_stop)
   );

   typedef struct { int due; logic [7:0] v; } byte_exp_t;
   typedef struct { int due; bit ack; } ack_exp_t;
   typedef struct { int due; bit full; bit tvld; bit ovf; bit stop; } st_exp_t;

   byte_exp_t  din_q[$];
   ack_exp_t   ack_q[$];
   st_exp_t    st_q[$];
   logic [7:0] tx_q[$];

   int checks = 0;
   int errors = 0;
   int tcyc = 0;

   always @(posedge clk_in) tcyc <= tcyc + 1;

   // reference model state
   logic [7:0]  ram_m [int];
   int          m_count;
   bit          m_ovf;
   bit          m_stop;
   int          m_phase;   // 0 running, 1 stop requested, 2 terminator queued, 3 stopped
   logic [31:0] m_cnt;
   logic [31:0] m_snap;

   bit         g_rdy = 1'b0;
   bit         g_rxv = 1'b0;
   logic [7:0] g_rxd = 8'h00;

   task automatic step(input bit rst, input logic [31:0] a, input bit wr, input logic [7:0] d);
      byte_exp_t  be;
      ack_exp_t   ae;
      st_exp_t    se;
      bit         pop;
      bit         io;
      bit         want_push;
      logic [7:0] pdata;
      logic [17:0] a18;
      int         ph0;
      @(posedge clk_in);
      #1;
      rst_in      = rst;
      in_mem_a    = a;
      in_mem_wr   = wr;
      in_mem_dout = d;
      in_tx_ready = g_rdy;
      in_rx_valid = g_rxv;
      in_rx_data  = g_rxd;
      be.due = tcyc + 1;
      be.v   = 8'h00;
      ae.due = tcyc;
      ae.ack = 1'b0;
      se.due = tcyc + 1;
      if (rst) begin
         m_count = 0;
         tx_q.delete();
         m_ovf   = 1'b0;
         m_stop  = 1'b0;
         m_phase = 0;
         m_cnt   = 32'd0;
         m_snap  = 32'd0;
      end else begin
         a18       = a[17:0];
         io        = (a18[17:16] == 2'b11);
         pop       = g_rdy && (m_count > 0);
         want_push = 1'b0;
         pdata     = d;
         ph0       = m_phase;
         if (wr) begin
            if (!io) begin
               ram_m[int'(a[16:0])] = d;
            end else if (ph0 == 0) begin
               if (a18 == 18'h30000 && d != 8'h00) want_push = 1'b1;
               if (a18 == 18'h30004) m_phase = 1;
            end
         end else if (!io) begin
            be.v = ram_m[int'(a[16:0])];
         end else begin
            case (a18)
               18'h30000: if (g_rxv) begin be.v = g_rxd; ae.ack = 1'b1; end
               18'h30004: begin m_snap = m_cnt; be.v = m_cnt[7:0]; end
               18'h30005: be.v = m_snap[15:8];
               18'h30006: be.v = m_snap[23:16];
               18'h30007: be.v = m_snap[31:24];
               default: be.v = 8'h00;
            endcase
         end
         if (ph0 == 1 && (m_count < 8 || pop)) begin
            want_push = 1'b1;
            pdata     = 8'h00;
            m_phase   = 2;
         end else if (ph0 == 2 && m_count == 0) begin
            m_phase = 3;
            m_stop  = 1'b1;
         end
         if (want_push) begin
            if (m_count < 8 || pop) begin
               tx_q.push_back(pdata);
               m_count++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (pop) m_count--;
         m_cnt = m_cnt + 32'd1;
      end
      se.full = (m_count >= 7);
      se.tvld = (m_count > 0);
      se.ovf  = m_ovf;
      se.stop = m_stop;
      din_q.push_back(be);
      ack_q.push_back(ae);
      st_q.push_back(se);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0003000C, 1'b0, 8'h00);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 32'h0003000C, 1'b0, 8'h00);
   endtask

   // monitor: compare every expectation that falls due in this cycle
   byte_exp_t  mb;
   ack_exp_t   ma;
   st_exp_t    ms;
   logic [7:0] mt;
   always @(negedge clk_in) begin
      while (ack_q.size() > 0 && ack_q[0].due <= tcyc) begin
         ma = ack_q.pop_front();
         checks++;
         if (out_rx_ack !== ma.ack) begin
            errors++;
            $display("FAIL rx_ack cyc %0d got %b want %b", tcyc, out_rx_ack, ma.ack);
         end
      end
      while (din_q.size() > 0 && din_q[0].due <= tcyc) begin
         mb = din_q.pop_front();
         checks++;
         if (out_mem_din !== mb.v) begin
            errors++;
            $display("FAIL mem_din cyc %0d got %h want %h", tcyc, out_mem_din, mb.v);
         end
      end
      while (st_q.size() > 0 && st_q[0].due <= tcyc) begin
         ms = st_q.pop_front();
         checks++;
         if (out_io_full !== ms.full || out_tx_valid !== ms.tvld ||
             out_tx_ovf !== ms.ovf || out_stop !== ms.stop) begin
            errors++;
            $display("FAIL status cyc %0d got full=%b vld=%b ovf=%b stop=%b want full=%b vld=%b ovf=%b stop=%b",
                     tcyc, out_io_full, out_tx_valid, out_tx_ovf, out_stop,
                     ms.full, ms.tvld, ms.ovf, ms.stop);
         end
      end
      if (rst_in === 1'b0 && out_tx_valid === 1'b1 && in_tx_ready === 1'b1) begin
         checks++;
         if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL tx_extra cyc %0d got %h want none", tcyc, out_tx_data);
         end else begin
            mt = tx_q.pop_front();
            if (out_tx_data !== mt) begin
               errors++;
               $display("FAIL tx_data cyc %0d got %h want %h", tcyc, out_tx_data, mt);
            end
         end
      end
   end

   logic [16:0] pool [8];
   logic [31:0] ra;
   logic [7:0]  rd;
   logic [15:0] lo;
   int unsigned r;
   int unsigned p;

   initial begin
      for (int i = 0; i < 8; i++) pool[i] = 17'($urandom);

      do_reset(2);
      idle(1);

      // RAM write then read-back of the fresh byte
      step(1'b0, 32'h00000010, 1'b1, 8'hA5);
      step(1'b0, 32'h00000010, 1'b0, 8'h00);
      idle(1);
      for (int i = 0; i < 8; i++) step(1'b0, {15'd0, pool[i]}, 1'b1, 8'($urandom));

      // tx of "Hi" with terminating zero ignored
      g_rdy = 1'b1;
      step(1'b0, 32'h00030000, 1'b1, 8'h48);
      step(1'b0, 32'h00030000, 1'b1, 8'h69);
      step(1'b0, 32'h00030000, 1'b1, 8'h00);
      idle(4);

      // fill while stalled: near-full flag, then a dropped byte
      g_rdy = 1'b0;
      for (int i = 0; i < 9; i++) step(1'b0, 32'h00030000, 1'b1, 8'(8'h10 + i));
      idle(2);
      g_rdy = 1'b1;
      idle(12);

      // counter snapshot: bytes 1..3 stay coherent while the counter moves on
      do_reset(1);
      idle(32'h123);
      step(1'b0, 32'h00030004, 1'b0, 8'h00);
      idle(3);
      step(1'b0, 32'h00030005, 1'b0, 8'h00);
      idle(300);
      step(1'b0, 32'h00030006, 1'b0, 8'h00);
      step(1'b0, 32'h00030007, 1'b0, 8'h00);

      // rx read with and without a byte waiting
      g_rxv = 1'b1; g_rxd = 8'h3C;
      step(1'b0, 32'h00030000, 1'b0, 8'h00);
      g_rxv = 1'b0; g_rxd = 8'h99;
      step(1'b0, 32'h00030000, 1'b0, 8'h00);
      idle(1);

      // randomized mix of RAM, tx, rx and counter traffic
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         p = $urandom_range(0, 7);
         g_rdy = 1'($urandom);
         g_rxv = 1'($urandom);
         g_rxd = 8'($urandom);
         ra = {14'($urandom), (pool[p][16] ? 1'b0 : 1'($urandom)), pool[p]};
         rd = 8'($urandom);
         case (r)
            0, 1, 2: step(1'b0, ra, 1'b1, rd);
            3, 4:    step(1'b0, ra, 1'b0, 8'h00);
            5, 6:    step(1'b0, {14'($urandom), 18'h30000}, 1'b1,
                          ($urandom_range(0, 3) == 0) ? 8'h00 : rd);
            7:       step(1'b0, {14'($urandom), 18'h30000}, 1'b0, 8'h00);
            8:       step(1'b0, {14'($urandom), 18'h30004 + 18'($urandom_range(0, 3))}, 1'b0, 8'h00);
            default: begin
               lo = 16'($urandom);
               if (lo == 16'h0004) lo = 16'h0008;
               step(1'b0, {14'($urandom), 2'b11, lo}, 1'($urandom), rd);
            end
         endcase
      end
      g_rxv = 1'b0;
      g_rdy = 1'b1;
      idle(12);

      // stop request while the FIFO is full and the uart is stalled
      do_reset(1);
      g_rdy = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 32'h00030000, 1'b1, 8'(8'h41 + i));
      step(1'b0, 32'h00030004, 1'b1, 8'h01);
      idle(3);
      step(1'b0, 32'h00030000, 1'b1, 8'h55);
      g_rdy = 1'b1;
      idle(14);
      step(1'b0, 32'h00030000, 1'b1, 8'h77);
      step(1'b0, {15'd0, pool[0]}, 1'b1, 8'hC3);
      step(1'b0, {15'd0, pool[0]}, 1'b0, 8'h00);
      idle(3);
      checks++;
      if (out_stop !== 1'b1 || out_tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL stop_final got stop=%b vld=%b want stop=1 vld=0", out_stop, out_tx_valid);
      end
      checks++;
      if (tx_q.size() != 0) begin
         errors++;
         $display("FAIL tx_leftover got %0d bytes want 0", tx_q.size());
      end

      // reset while a stop is pending, then normal service resumes
      g_rdy = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 32'h00030000, 1'b1, 8'(8'h61 + i));
      step(1'b0, 32'h00030004, 1'b1, 8'h00);
      idle(2);
      do_reset(1);
      g_rdy = 1'b1;
      step(1'b0, 32'h00030000, 1'b1, 8'h5A);
      step(1'b0, 32'h00030000, 1'b1, 8'h5B);
      idle(6);

      @(negedge clk_in);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
